// File: rtl/conv_scheduler_if.sv
// -----------------------------------------------------------------------------
// conv_scheduler_if
// Purpose : bundles the job-control, convolve-engine and destination-write
//           signals of conv_scheduler into one interface.
// Modports:
//   master - the scheduler: drives o_*, samples i_*
//   slave  - the environment (job source, engine, memory): drives i_*
// Signals :
//   i_start, i_src_base, i_kernal_base, i_dest_base, i_stride,
//   i_out_rows, i_out_cols                    job request
//   o_conv_start, o_conv_src_addr, o_conv_kernal_addr,
//   i_conv_done, i_conv_sum1, i_conv_sum2     engine handshake
//   o_wr_en, o_wr_addr, o_wr_data             destination write port
//   o_busy, o_done, o_err                     job status
// -----------------------------------------------------------------------------
interface conv_scheduler_if;
  logic       i_start;
  logic [9:0] i_src_base;
  logic [9:0] i_kernal_base;
  logic [9:0] i_dest_base;
  logic [2:0] i_stride;
  logic [4:0] i_out_rows;
  logic [4:0] i_out_cols;

  logic       o_conv_start;
  logic [9:0] o_conv_src_addr;
  logic [9:0] o_conv_kernal_addr;
  logic       i_conv_done;
  logic [7:0] i_conv_sum1;
  logic [7:0] i_conv_sum2;

  logic       o_wr_en;
  logic [9:0] o_wr_addr;
  logic [7:0] o_wr_data;

  logic       o_busy;
  logic       o_done;
  logic       o_err;

  modport master (
    input  i_start, i_src_base, i_kernal_base, i_dest_base, i_stride,
           i_out_rows, i_out_cols, i_conv_done, i_conv_sum1, i_conv_sum2,
    output o_conv_start, o_conv_src_addr, o_conv_kernal_addr,
           o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_err
  );

  modport slave (
    output i_start, i_src_base, i_kernal_base, i_dest_base, i_stride,
           i_out_rows, i_out_cols, i_conv_done, i_conv_sum1, i_conv_sum2,
    input  o_conv_start, o_conv_src_addr, o_conv_kernal_addr,
           o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_err
  );
endinterface

// File: rtl/conv_scheduler.sv
// -----------------------------------------------------------------------------
// conv_scheduler
// Purpose : walks an out_rows x out_cols output map two pixels at a time,
//           starts the convolve engine for each pair, waits for its two sums
//           and writes them densely into the destination buffer.
// Ports   :
//   clk  - single clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - conv_scheduler_if.master (job request, engine handshake,
//          destination write port, busy/done/err status)
// Params  :
//   IMG_COLS - source image row pitch in words
//   TIMEOUT  - engine wait limit in cycles (only with SCHED_TIMEOUT_EN)
// Config  :
//   `define SCHED_TIMEOUT_EN to abandon a job with o_err when the engine does
//   not answer within TIMEOUT cycles; without it the WAIT state has no limit.
// All outputs are registered; addresses wrap modulo 1024.
// -----------------------------------------------------------------------------
module conv_scheduler #(
  parameter int IMG_COLS = 28,
  parameter int TIMEOUT  = 1023
) (
  input  logic             clk,
  input  logic             rst,
  conv_scheduler_if.master bus
);

  localparam logic [9:0] LP_IMG_COLS = 10'(IMG_COLS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WR1   = 3'd3,
    S_WR2   = 3'd4,
    S_NEXT  = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Row pitch stride*IMG_COLS built by shift-and-add (stride is only 3 bits).
  function automatic logic [9:0] f_row_pitch(input logic [2:0] stride);
    logic [9:0] acc;
    acc = 10'd0;
    if (stride[0]) acc = acc + LP_IMG_COLS;
    else           acc = acc;
    if (stride[1]) acc = acc + (LP_IMG_COLS << 1);
    else           acc = acc;
    if (stride[2]) acc = acc + (LP_IMG_COLS << 2);
    else           acc = acc;
    return acc;
  endfunction

  // Output registers
  logic       r_conv_start;
  logic [9:0] r_src_addr;
  logic [9:0] r_kernal_addr;
  logic       r_wr_en;
  logic [9:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic       r_busy;
  logic       r_done;
  logic       r_err;

  // Latched job and walk state
  logic [4:0] r_out_rows;
  logic [4:0] r_out_cols;
  logic [4:0] r_row;
  logic [4:0] r_col;
  logic [9:0] r_row_base;   // source address of (r, 0)
  logic [9:0] r_row_pitch;  // stride * IMG_COLS
  logic [9:0] r_col_step;   // 2 * stride
  logic [9:0] r_wr_ptr;     // next destination address
  logic [7:0] r_sum2;       // second sum held for WR2

  // Control strobes from the next-state logic
  logic       w_cfg_ok;
  logic       w_accept;
  logic       w_cfg_err;
  logic       w_timeout;
  logic       w_finish;
  logic       w_wait_expired;

  // Walk arithmetic, one bit wider so the end-of-row compare cannot overflow
  logic [5:0] w_col_inc;
  logic       w_row_wrap;
  logic [5:0] w_row_inc;
  logic       w_job_last;
  logic       w_has_pair2;

  assign w_cfg_ok    = (bus.i_stride != 3'd0) && (bus.i_out_rows != 5'd0) &&
                       (bus.i_out_cols != 5'd0);
  assign w_col_inc   = {1'b0, r_col} + 6'd2;
  assign w_row_wrap  = (w_col_inc >= {1'b0, r_out_cols});
  assign w_row_inc   = {1'b0, r_row} + 6'd1;
  assign w_job_last  = w_row_wrap && (w_row_inc >= {1'b0, r_out_rows});
  assign w_has_pair2 = (({1'b0, r_col} + 6'd1) < {1'b0, r_out_cols});

`ifdef SCHED_TIMEOUT_EN
  localparam int               LP_TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [LP_TW-1:0] LP_TO_LAST = LP_TW'(TIMEOUT - 1);

  logic [LP_TW-1:0] r_wait_cnt;

  // Counts WAIT cycles without engine completion; expires on the TIMEOUT-th.
  assign w_wait_expired = (r_wait_cnt == LP_TO_LAST);

  // WAIT-cycle counter, cleared in every other state and on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if ((r_state == S_WAIT) && !bus.i_conv_done) begin
      r_wait_cnt <= r_wait_cnt + LP_TW'(1);
    end else begin
      r_wait_cnt <= '0;
    end
  end
`else
  assign w_wait_expired = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_cfg_err   = 1'b0;
    w_timeout   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          if (w_cfg_ok) begin
            w_accept    = 1'b1;
            w_state_nxt = S_ISSUE;
          end else begin
            w_cfg_err   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.i_conv_done) begin
          w_state_nxt = S_WR1;
        end else if (w_wait_expired) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WR1: begin
        if (w_has_pair2) begin
          w_state_nxt = S_WR2;
        end else begin
          w_state_nxt = S_NEXT;
        end
      end
      S_WR2: begin
        w_state_nxt = S_NEXT;
      end
      S_NEXT: begin
        if (w_job_last) begin
          w_finish    = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_ISSUE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered outputs, job latch, address accumulators and walk counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_conv_start  <= 1'b0;
      r_src_addr    <= 10'd0;
      r_kernal_addr <= 10'd0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= 10'd0;
      r_wr_data     <= 8'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_out_rows    <= 5'd0;
      r_out_cols    <= 5'd0;
      r_row         <= 5'd0;
      r_col         <= 5'd0;
      r_row_base    <= 10'd0;
      r_row_pitch   <= 10'd0;
      r_col_step    <= 10'd0;
      r_wr_ptr      <= 10'd0;
      r_sum2        <= 8'd0;
    end else begin
      // Strobes are registered against the state being entered, so each
      // one is high for exactly the cycle spent in that state.
      r_conv_start <= (w_state_nxt == S_ISSUE);
      r_wr_en      <= (w_state_nxt == S_WR1) || (w_state_nxt == S_WR2);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_done       <= w_finish;
      r_err        <= w_cfg_err || w_timeout;

      if (w_accept) begin
        r_src_addr    <= bus.i_src_base;
        r_row_base    <= bus.i_src_base;
        r_kernal_addr <= bus.i_kernal_base;
        r_wr_ptr      <= bus.i_dest_base;
        r_row_pitch   <= f_row_pitch(bus.i_stride);
        r_col_step    <= {6'd0, bus.i_stride, 1'b0};
        r_out_rows    <= bus.i_out_rows;
        r_out_cols    <= bus.i_out_cols;
        r_row         <= 5'd0;
        r_col         <= 5'd0;
      end else if ((r_state == S_WAIT) && bus.i_conv_done) begin
        // sum1 goes straight to the write port; sum2 waits for WR2.
        r_wr_addr <= r_wr_ptr;
        r_wr_data <= bus.i_conv_sum1;
        r_sum2    <= bus.i_conv_sum2;
        r_wr_ptr  <= r_wr_ptr + 10'd1;
      end else if ((r_state == S_WR1) && w_has_pair2) begin
        r_wr_addr <= r_wr_ptr;
        r_wr_data <= r_sum2;
        r_wr_ptr  <= r_wr_ptr + 10'd1;
      end else if ((r_state == S_NEXT) && !w_job_last) begin
        if (w_row_wrap) begin
          r_col      <= 5'd0;
          r_row      <= r_row + 5'd1;
          r_row_base <= r_row_base + r_row_pitch;
          r_src_addr <= r_row_base + r_row_pitch;
        end else begin
          r_col      <= r_col + 5'd2;
          r_src_addr <= r_src_addr + r_col_step;
        end
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
    end
  end

  assign bus.o_conv_start       = r_conv_start;
  assign bus.o_conv_src_addr    = r_src_addr;
  assign bus.o_conv_kernal_addr = r_kernal_addr;
  assign bus.o_wr_en            = r_wr_en;
  assign bus.o_wr_addr          = r_wr_addr;
  assign bus.o_wr_data          = r_wr_data;
  assign bus.o_busy             = r_busy;
  assign bus.o_done             = r_done;
  assign bus.o_err              = r_err;

endmodule

// File: tb/tb_conv_scheduler.sv
// -----------------------------------------------------------------------------
// tb_conv_scheduler
// Randomized self-checking bench for conv_scheduler. A behavioural engine
// answers every o_conv_start with random sums after a chosen latency; the
// reference model rebuilds the expected start addresses and the dense write
// stream from the job parameters and the sums the engine handed out.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_conv_scheduler;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  conv_scheduler_if bus();

  conv_scheduler #(.IMG_COLS(28), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [9:0]  st_src_q[$];
  logic [9:0]  st_ker_q[$];
  logic [9:0]  wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  logic [15:0] sum_q[$];

  int done_cnt    = 0;
  int err_cnt     = 0;
  int overlap_cnt = 0;
  int start_cyc   = 0;
  int err_cyc     = 0;

  bit eng_on      = 1'b1;
  int eng_lat     = 0;
  bit eng_pending = 1'b0;
  int eng_wait    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    st_src_q.delete();
    st_ker_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    sum_q.delete();
    done_cnt    = 0;
    err_cnt     = 0;
    overlap_cnt = 0;
  endtask

  task automatic drive_job(input logic [9:0] src, input logic [9:0] ker, input logic [9:0] dest,
                           input logic [2:0] stride, input logic [4:0] rows, input logic [4:0] cols);
    bus.i_src_base    = src;
    bus.i_kernal_base = ker;
    bus.i_dest_base   = dest;
    bus.i_stride      = stride;
    bus.i_out_rows    = rows;
    bus.i_out_cols    = cols;
    bus.i_start       = 1'b1;
  endtask

  // Behavioural engine plus output monitor, sampled on the falling edge.
  initial begin
    logic [15:0] s;
    bus.i_conv_done = 1'b0;
    bus.i_conv_sum1 = 8'd0;
    bus.i_conv_sum2 = 8'd0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.i_conv_done = 1'b0;
      if (rst) begin
        eng_pending = 1'b0;
      end else begin
        if (eng_pending) begin
          if (eng_wait == 0) begin
            s = 16'($urandom);
            bus.i_conv_sum1 = s[15:8];
            bus.i_conv_sum2 = s[7:0];
            bus.i_conv_done = 1'b1;
            sum_q.push_back(s);
            eng_pending = 1'b0;
          end else begin
            eng_wait--;
          end
        end
        if (bus.o_conv_start === 1'b1) begin
          if (eng_pending) overlap_cnt++;
          st_src_q.push_back(bus.o_conv_src_addr);
          st_ker_q.push_back(bus.o_conv_kernal_addr);
          start_cyc = cyc;
          if (eng_on) begin
            eng_pending = 1'b1;
            eng_wait    = ((eng_lat > 0) ? eng_lat : int'($urandom_range(6, 1))) - 1;
          end
        end
      end
      if (bus.o_wr_en === 1'b1) begin
        wr_addr_q.push_back(bus.o_wr_addr);
        wr_data_q.push_back(bus.o_wr_data);
      end
      if (bus.o_done === 1'b1) done_cnt++;
      if (bus.o_err === 1'b1) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
  end

  // Runs one legal job to completion and checks it against the model.
  task automatic run_job(input logic [9:0] src, input logic [9:0] ker, input logic [9:0] dest,
                         input logic [2:0] stride, input logic [4:0] rows, input logic [4:0] cols,
                         input int lat, input bit poke);
    int guard;
    int p;
    int idx;
    int es;
    logic [15:0] s;
    clear_log();
    eng_on  = 1'b1;
    eng_lat = lat;
    drive_job(src, ker, dest, stride, rows, cols);
    step();
    bus.i_start = 1'b0;
    check_eq("busy_after_accept", 32'(bus.o_busy), 32'd1);
    guard = 0;
    while (done_cnt == 0 && err_cnt == 0 && guard < 3000) begin
      step();
      guard++;
      if (poke && guard == 7) begin
        // A second request mid-job must be ignored and must not disturb the latched job.
        drive_job(~src, ker + 10'd3, dest + 10'd37, 3'd7, 5'd9, 5'd9);
      end else begin
        bus.i_start = 1'b0;
      end
    end
    bus.i_start = 1'b0;
    check_eq("job_completes", 32'(guard < 3000), 32'd1);
    check_eq("busy_low_at_done", 32'(bus.o_busy), 32'd0);
    repeat (3) step();
    check_eq("done_pulses", 32'(done_cnt), 32'd1);
    check_eq("no_err", 32'(err_cnt), 32'd0);
    check_eq("one_outstanding", 32'(overlap_cnt), 32'd0);
    check_eq("n_starts", 32'(st_src_q.size()), 32'(((int'(cols) + 1) / 2) * int'(rows)));
    check_eq("n_writes", 32'(wr_addr_q.size()), 32'(int'(rows) * int'(cols)));
    p   = 0;
    idx = 0;
    for (int r = 0; r < int'(rows); r++) begin
      for (int c = 0; c < int'(cols); c += 2) begin
        es = (int'(src) + r * int'(stride) * 28 + c * int'(stride)) % 1024;
        if (p < st_src_q.size()) begin
          check_eq($sformatf("start_src[%0d]", p), 32'(st_src_q[p]), 32'(es));
          check_eq($sformatf("start_ker[%0d]", p), 32'(st_ker_q[p]), 32'(ker));
        end
        if (p < sum_q.size()) begin
          s = sum_q[p];
          if (idx < wr_addr_q.size()) begin
            check_eq($sformatf("wr_addr[%0d]", idx), 32'(wr_addr_q[idx]), 32'((int'(dest) + idx) % 1024));
            check_eq($sformatf("wr_data[%0d]", idx), 32'(wr_data_q[idx]), 32'(s[15:8]));
          end
          idx++;
          if (c + 1 < int'(cols)) begin
            if (idx < wr_addr_q.size()) begin
              check_eq($sformatf("wr_addr[%0d]", idx), 32'(wr_addr_q[idx]), 32'((int'(dest) + idx) % 1024));
              check_eq($sformatf("wr_data[%0d]", idx), 32'(wr_data_q[idx]), 32'(s[7:0]));
            end
            idx++;
          end
        end
        p++;
      end
    end
  endtask

  // Illegal configuration: one error pulse, no engine start, never busy.
  task automatic bad_cfg(input logic [2:0] stride, input logic [4:0] rows, input logic [4:0] cols);
    clear_log();
    drive_job(10'd5, 10'd6, 10'd7, stride, rows, cols);
    step();
    bus.i_start = 1'b0;
    check_eq("cfg_err_pulse", 32'(bus.o_err), 32'd1);
    check_eq("cfg_err_not_busy", 32'(bus.o_busy), 32'd0);
    step();
    check_eq("cfg_err_one_cycle", 32'(bus.o_err), 32'd0);
    repeat (5) step();
    check_eq("cfg_err_no_start", 32'(st_src_q.size()), 32'd0);
    check_eq("cfg_err_count", 32'(err_cnt), 32'd1);
    check_eq("cfg_err_still_idle", 32'(bus.o_busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_conv_start"}, 32'(bus.o_conv_start), 32'd0);
    check_eq({tag, "_src_addr"}, 32'(bus.o_conv_src_addr), 32'd0);
    check_eq({tag, "_ker_addr"}, 32'(bus.o_conv_kernal_addr), 32'd0);
    check_eq({tag, "_wr_en"}, 32'(bus.o_wr_en), 32'd0);
    check_eq({tag, "_wr_addr"}, 32'(bus.o_wr_addr), 32'd0);
    check_eq({tag, "_wr_data"}, 32'(bus.o_wr_data), 32'd0);
    check_eq({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
    check_eq({tag, "_done"}, 32'(bus.o_done), 32'd0);
    check_eq({tag, "_err"}, 32'(bus.o_err), 32'd0);
  endtask

  initial begin
    int guard;
    rst               = 1'b1;
    bus.i_start       = 1'b0;
    bus.i_src_base    = 10'd0;
    bus.i_kernal_base = 10'd0;
    bus.i_dest_base   = 10'd0;
    bus.i_stride      = 3'd0;
    bus.i_out_rows    = 5'd0;
    bus.i_out_cols    = 5'd0;
    repeat (3) step();
    check_all_zero("reset");

    // Start requested on the very first edge after reset release.
    rst = 1'b0;
    run_job(10'd0, 10'd800, 10'd900, 3'd1, 5'd2, 5'd4, 5, 1'b0);
    if (st_src_q.size() == 4) begin
      check_eq("ex1_src3", 32'(st_src_q[3]), 32'd30);
    end else begin
      check_eq("ex1_nstarts", 32'(st_src_q.size()), 32'd4);
    end

    // Odd column count skips WR2 on the final pair.
    run_job(10'd10, 10'd55, 10'd200, 3'd2, 5'd1, 5'd3, 0, 1'b0);

    // Source and destination address wrap.
    run_job(10'd1020, 10'd1, 10'd1021, 3'd1, 5'd1, 5'd8, 0, 1'b0);
    if (st_src_q.size() >= 3) begin
      check_eq("wrap_start3", 32'(st_src_q[2]), 32'd0);
    end else begin
      check_eq("wrap_nstarts", 32'(st_src_q.size()), 32'd4);
    end

    // Illegal configurations.
    bad_cfg(3'd0, 5'd2, 5'd2);
    bad_cfg(3'd1, 5'd0, 5'd2);
    bad_cfg(3'd1, 5'd2, 5'd0);

    // Randomized jobs; one of them is hit by a mid-job start request.
    for (int t = 0; t < 8; t++) begin
      run_job(10'($urandom), 10'($urandom), 10'($urandom), 3'($urandom_range(7, 1)),
              5'($urandom_range(4, 1)), 5'($urandom_range(9, 1)), 0, (t == 2));
    end
    run_job(10'($urandom), 10'($urandom), 10'($urandom), 3'd7, 5'd3, 5'd31, 1, 1'b0);

    // Reset during WAIT of the second pair.
    clear_log();
    eng_on  = 1'b1;
    eng_lat = 10;
    drive_job(10'd40, 10'd300, 10'd500, 3'd1, 5'd2, 5'd4);
    step();
    bus.i_start = 1'b0;
    guard = 0;
    while (st_src_q.size() < 2 && guard < 200) begin
      step();
      guard++;
    end
    check_eq("reach_second_pair", 32'(guard < 200), 32'd1);
    step();
    step();
    check_eq("in_wait_busy", 32'(bus.o_busy), 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("midjob_rst");
    step();
    rst = 1'b0;
    run_job(10'd64, 10'd2, 10'd3, 3'd3, 5'd2, 5'd5, 0, 1'b0);

    // Engine never answers.
    clear_log();
    eng_on = 1'b0;
    drive_job(10'd100, 10'd200, 10'd300, 3'd1, 5'd1, 5'd2);
    step();
    bus.i_start = 1'b0;
`ifdef SCHED_TIMEOUT_EN
    guard = 0;
    while (err_cnt == 0 && guard < 200) begin
      step();
      guard++;
    end
    check_eq("to_err_seen", 32'(err_cnt), 32'd1);
    check_eq("to_err_latency", 32'(err_cyc - start_cyc), 32'd17);
    check_eq("to_busy_low", 32'(bus.o_busy), 32'd0);
    repeat (5) step();
    check_eq("to_no_done", 32'(done_cnt), 32'd0);
    check_eq("to_one_start", 32'(st_src_q.size()), 32'd1);
`else
    repeat (100) step();
    check_eq("hang_busy", 32'(bus.o_busy), 32'd1);
    check_eq("hang_no_err", 32'(err_cnt), 32'd0);
    check_eq("hang_no_done", 32'(done_cnt), 32'd0);
    check_eq("hang_one_start", 32'(st_src_q.size()), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("hang_cleared", 32'(bus.o_busy), 32'd0);
`endif
    eng_on = 1'b1;
    step();
    run_job(10'd7, 10'd8, 10'd9, 3'd2, 5'd2, 5'd3, 3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
